// File: rtl/ex_stage.sv
// Execute stage: operand select, ALU, branch target and destination mux, registered into the EX/MEM bundle.
// Define EX_MULT_EN to build the iterative radix-16 multiplier (IDLE/MULT FSM and ex_busy).
module ex_stage #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [1:0]            id_wb,
    input  logic [2:0]            id_m,
    input  logic [DATA_W-1:0]     id_pc4,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [4:0]            id_rt,
    input  logic [4:0]            id_rd,
    input  logic [1:0]            id_alu_op,
    input  logic                  id_alu_src,
    input  logic                  id_reg_dst,
    input  logic                  flush,
    output logic [2*DATA_W+10:0]  ex_mem_bundle,
    output logic [DATA_W-1:0]     ex_mem_store_data,
    output logic                  ex_busy
);

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    function automatic logic [DATA_W-1:0] alu_calc(
        input logic [1:0]               op,
        input logic [5:0]               funct,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] r;
        r = '0;
        case (op)
            2'b00, 2'b11: r = a + b;
            2'b01:        r = a - b;
            default: begin
                case (funct)
                    FN_ADD:  r = a + b;
                    FN_SUB:  r = a - b;
                    FN_AND:  r = a & b;
                    FN_OR:   r = a | b;
                    FN_SLT:  r = {{(DATA_W-1){1'b0}}, (a < b)};
                    default: r = '0;
                endcase
            end
        endcase
        return r;
    endfunction

    // ---- stage p0: combinational execute on the ID/EX inputs ----
    logic signed [DATA_W-1:0] opa_p0;
    logic signed [DATA_W-1:0] opb_p0;
    logic [DATA_W-1:0]        alu_p0;
    logic [DATA_W-1:0]        bt_p0;
    logic [4:0]               wr_p0;
    logic                     vld_p0;

    assign opa_p0 = id_rs_data;
    assign opb_p0 = id_alu_src ? id_imm : id_rt_data;
    assign alu_p0 = alu_calc(id_alu_op, id_imm[5:0], opa_p0, opb_p0);
    assign bt_p0  = id_pc4 + (id_imm << 2);
    assign wr_p0  = id_reg_dst ? id_rd : id_rt;
    assign vld_p0 = id_valid & ~flush;

`ifdef EX_MULT_EN
    localparam logic [5:0] FN_MUL = 6'h18;
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] MULT   = 1'b1;

    // Shift-add product of a with one 4-bit digit of the multiplier.
    function automatic logic [DATA_W-1:0] radix16_pp(
        input logic [DATA_W-1:0] a,
        input logic [3:0]        nib
    );
        logic [DATA_W-1:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            if (nib[i]) s = s + (a << i);
        end
        return s;
    endfunction

    logic [0:0]        state_p1;
    logic [2:0]        cnt_p1;
    logic [DATA_W-1:0] a_sh_p1;
    logic [DATA_W-1:0] b_sh_p1;
    logic [DATA_W-1:0] acc_p1;
    logic [1:0]        wb_p1;
    logic [2:0]        m_p1;
    logic [DATA_W-1:0] bt_p1;
    logic [4:0]        wr_p1;
    logic [DATA_W-1:0] st_p1;
    logic              is_mul_p0;
    logic              mul_start_p0;
    logic [DATA_W-1:0] prod_p1;

    assign is_mul_p0    = (id_alu_op == 2'b10) && (id_imm[5:0] == FN_MUL);
    assign mul_start_p0 = (state_p1 == IDLE) && vld_p0 && is_mul_p0;
    assign prod_p1      = acc_p1 + radix16_pp(a_sh_p1, b_sh_p1[3:0]);
    assign ex_busy      = (state_p1 == MULT) || (id_valid && is_mul_p0);

    // ---- stage p1: EX/MEM register and multiply sequencing ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p1          <= IDLE;
            cnt_p1            <= 3'd0;
            ex_mem_bundle     <= '0;
            ex_mem_store_data <= '0;
        end else if (state_p1 == MULT) begin
            ex_mem_bundle     <= '0;
            ex_mem_store_data <= '0;
            cnt_p1            <= cnt_p1 + 3'd1;
            if (flush) begin
                state_p1 <= IDLE;
            end else if (cnt_p1 == 3'd7) begin
                state_p1          <= IDLE;
                ex_mem_bundle     <= {wb_p1, m_p1, bt_p1, prod_p1, (prod_p1 == '0), wr_p1};
                ex_mem_store_data <= st_p1;
            end
        end else if (mul_start_p0) begin
            state_p1          <= MULT;
            cnt_p1            <= 3'd0;
            ex_mem_bundle     <= '0;
            ex_mem_store_data <= '0;
        end else if (vld_p0) begin
            ex_mem_bundle     <= {id_wb, id_m, bt_p0, alu_p0, (alu_p0 == '0), wr_p0};
            ex_mem_store_data <= id_rt_data;
        end else begin
            ex_mem_bundle     <= '0;
            ex_mem_store_data <= '0;
        end
    end

    // Operands and bundle fields held for the duration of the multiply; the
    // multiplicand shifts up and the multiplier down one digit per cycle.
    always_ff @(posedge clk) begin
        if (mul_start_p0) begin
            a_sh_p1 <= opa_p0;
            b_sh_p1 <= opb_p0;
            acc_p1  <= '0;
            wb_p1   <= id_wb;
            m_p1    <= id_m;
            bt_p1   <= bt_p0;
            wr_p1   <= wr_p0;
            st_p1   <= id_rt_data;
        end else if (state_p1 == MULT) begin
            a_sh_p1 <= a_sh_p1 << 4;
            b_sh_p1 <= b_sh_p1 >> 4;
            acc_p1  <= prod_p1;
        end
    end
`else
    assign ex_busy = 1'b0;

    // ---- stage p1: EX/MEM register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_mem_bundle     <= '0;
            ex_mem_store_data <= '0;
        end else if (vld_p0) begin
            ex_mem_bundle     <= {id_wb, id_m, bt_p0, alu_p0, (alu_p0 == '0), wr_p0};
            ex_mem_store_data <= id_rt_data;
        end else begin
            ex_mem_bundle     <= '0;
            ex_mem_store_data <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, multi-cycle corner sequences
// and randomized instructions checked against a behavioural model.
module tb_ex_stage;

`ifdef EX_MULT_EN
    localparam bit MULT_EN = 1'b1;
`else
    localparam bit MULT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [1:0]  id_wb;
    logic [2:0]  id_m;
    logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rt, id_rd;
    logic [1:0]  id_alu_op;
    logic        id_alu_src, id_reg_dst, flush;
    logic [74:0] ex_mem_bundle;
    logic [31:0] ex_mem_store_data;
    logic        ex_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_wb(id_wb), .id_m(id_m),
        .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
        .id_reg_dst(id_reg_dst), .flush(flush), .ex_mem_bundle(ex_mem_bundle),
        .ex_mem_store_data(ex_mem_store_data), .ex_busy(ex_busy)
    );

    typedef struct {
        logic        valid, flush;
        logic [1:0]  op;
        logic        src, rdst;
        logic [31:0] rs, rt, imm, pc4;
        logic [4:0]  rt_i, rd_i;
        logic [1:0]  wb;
        logic [2:0]  m;
    } in_t;

    typedef struct {
        in_t         in;
        logic [74:0] exp;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [74:0] act, input logic [74:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [74:0] mk(input logic [1:0] wb, input logic [2:0] m,
                                       input logic [31:0] bt, input logic [31:0] alu,
                                       input logic [4:0] wr);
        return {wb, m, bt, alu, (alu == 32'd0), wr};
    endfunction

    function automatic bit is_mul(input in_t x);
        return x.op == 2'b10 && x.imm[5:0] == 6'h18;
    endfunction

    function automatic logic [31:0] model_alu(input in_t x);
        logic [31:0] b;
        b = x.src ? x.imm : x.rt;
        if (x.op == 2'b01) return x.rs - b;
        if (x.op != 2'b10) return x.rs + b;
        case (x.imm[5:0])
            6'h20:   return x.rs + b;
            6'h22:   return x.rs - b;
            6'h24:   return x.rs & b;
            6'h25:   return x.rs | b;
            6'h2A:   return ($signed(x.rs) < $signed(b)) ? 32'd1 : 32'd0;
            6'h18:   return MULT_EN ? x.rs * b : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [74:0] model_bundle(input in_t x);
        if (!x.valid || x.flush) return '0;
        return mk(x.wb, x.m, x.pc4 + (x.imm << 2), model_alu(x), x.rdst ? x.rd_i : x.rt_i);
    endfunction

    task automatic set_inputs(input in_t x);
        id_valid = x.valid;  flush = x.flush;   id_alu_op = x.op;
        id_alu_src = x.src;  id_reg_dst = x.rdst;
        id_rs_data = x.rs;   id_rt_data = x.rt; id_imm = x.imm; id_pc4 = x.pc4;
        id_rt = x.rt_i;      id_rd = x.rd_i;    id_wb = x.wb;   id_m = x.m;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction, follows a multiply through its bubbles, checks the result.
    task automatic apply(input string nm, input in_t x);
        bit started;
        started = MULT_EN && x.valid && !x.flush && is_mul(x);
        set_inputs(x);
        #1;
        chk({nm, " busy0"}, 75'(ex_busy), 75'(MULT_EN && x.valid && is_mul(x)));
        if (started) begin
            for (int k = 1; k <= 8; k++) begin
                step();
                chk({nm, " mul bubble"}, ex_mem_bundle, '0);
                chk({nm, " mul busy"}, 75'(ex_busy), 75'(1));
            end
        end
        step();
        chk({nm, " bundle"}, ex_mem_bundle, model_bundle(x));
        chk({nm, " store"}, 75'(ex_mem_store_data),
            75'((x.valid && !x.flush) ? x.rt : 32'd0));
    endtask

    function automatic in_t rand_in();
        in_t x;
        logic [31:0] r;
        logic [5:0]  fns[6];
        int          sel;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18};
        r = $urandom();
        x.op = 2'($urandom_range(0, 3));
        sel = $urandom_range(0, 6);
        x.imm = (sel == 6) ? r : {r[31:6], fns[sel]};
        x.valid = ($urandom_range(0, 9) != 0);
        x.flush = ($urandom_range(0, 9) == 0);
        x.src   = 1'($urandom_range(0, 1));
        x.rdst  = 1'($urandom_range(0, 1));
        x.rs    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
        x.rt    = ($urandom_range(0, 3) == 0) ? x.rs : $urandom();
        x.pc4   = $urandom() & 32'hFFFF_FFFC;
        x.rt_i  = 5'($urandom_range(0, 31));
        x.rd_i  = 5'($urandom_range(0, 31));
        x.wb    = 2'($urandom_range(0, 3));
        x.m     = 3'($urandom_range(0, 7));
        return x;
    endfunction

    in_t add_in, mul_in, idle_in;

    initial begin
        //            valid flush op    src   rdst  rs             rt             imm            pc4            rt_i  rd_i   wb     m
        tbl[0]  = '{'{1'b1,1'b0,2'b10,1'b0,1'b1,32'd5,        32'd7,        32'h20,       32'h100,5'd2,5'd3, 2'b10,3'b000}, mk(2'b10,3'b000,32'h180,32'd12,5'd3)};
        tbl[1]  = '{'{1'b1,1'b0,2'b01,1'b0,1'b0,32'd3,        32'd3,        32'd4,        32'h100,5'd5,5'd0, 2'b00,3'b100}, mk(2'b00,3'b100,32'h110,32'd0,5'd5)};
        tbl[2]  = '{'{1'b1,1'b0,2'b10,1'b0,1'b1,32'hFFFFFFFF, 32'd1,        32'h2A,       32'h100,5'd4,5'd8, 2'b10,3'b000}, mk(2'b10,3'b000,32'h1A8,32'd1,5'd8)};
        tbl[3]  = '{'{1'b1,1'b0,2'b10,1'b0,1'b1,32'd1,        32'hFFFFFFFF, 32'h2A,       32'h100,5'd4,5'd8, 2'b10,3'b000}, mk(2'b10,3'b000,32'h1A8,32'd0,5'd8)};
        tbl[4]  = '{'{1'b1,1'b0,2'b10,1'b0,1'b1,32'd3,        32'd5,        32'h22,       32'h100,5'd1,5'd9, 2'b10,3'b000}, mk(2'b10,3'b000,32'h188,32'hFFFFFFFE,5'd9)};
        tbl[5]  = '{'{1'b1,1'b0,2'b10,1'b0,1'b1,32'hF0F0F0F0, 32'hFF00FF00, 32'h24,       32'h100,5'd1,5'd10,2'b10,3'b000}, mk(2'b10,3'b000,32'h190,32'hF000F000,5'd10)};
        tbl[6]  = '{'{1'b1,1'b0,2'b10,1'b0,1'b1,32'h0F,       32'hF0,       32'h25,       32'h100,5'd1,5'd11,2'b10,3'b000}, mk(2'b10,3'b000,32'h194,32'hFF,5'd11)};
        tbl[7]  = '{'{1'b1,1'b0,2'b10,1'b0,1'b1,32'd1,        32'd2,        32'h27,       32'h100,5'd1,5'd12,2'b10,3'b000}, mk(2'b10,3'b000,32'h19C,32'd0,5'd12)};
        tbl[8]  = '{'{1'b1,1'b0,2'b00,1'b1,1'b0,32'h1000,     32'hDEAD,     32'hFFFFFFFC, 32'h100,5'd9,5'd1, 2'b11,3'b010}, mk(2'b11,3'b010,32'hF0,32'hFFC,5'd9)};
        tbl[9]  = '{'{1'b1,1'b0,2'b11,1'b0,1'b0,32'hFFFFFFFF, 32'd1,        32'd0,        32'h200,5'd6,5'd0, 2'b10,3'b000}, mk(2'b10,3'b000,32'h200,32'd0,5'd6)};
        tbl[10] = '{'{1'b0,1'b0,2'b10,1'b0,1'b1,32'd5,        32'd7,        32'h20,       32'h100,5'd2,5'd3, 2'b10,3'b000}, 75'd0};
        tbl[11] = '{'{1'b1,1'b1,2'b10,1'b0,1'b1,32'd5,        32'd7,        32'h20,       32'h100,5'd2,5'd3, 2'b10,3'b000}, 75'd0};
        tbl[12] = '{'{1'b1,1'b0,2'b00,1'b1,1'b0,32'h20,       32'h1234,     32'd8,        32'h100,5'd7,5'd2, 2'b00,3'b001}, mk(2'b00,3'b001,32'h120,32'h28,5'd7)};

        add_in  = tbl[0].in;
        mul_in  = '{1'b1,1'b0,2'b10,1'b0,1'b1,32'd6,32'd7,32'h18,32'h400,5'd1,5'd4,2'b10,3'b000};
        idle_in = add_in;
        idle_in.valid = 1'b0;

        // Reset beats a valid instruction presented at the same edges.
        reset = 1'b1;
        set_inputs(add_in);
        step();
        step();
        chk("reset bundle", ex_mem_bundle, '0);
        chk("reset store", 75'(ex_mem_store_data), '0);
        chk("reset busy", 75'(ex_busy), '0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            set_inputs(tbl[i].in);
            step();
            chk($sformatf("vec%0d bundle", i), ex_mem_bundle, tbl[i].exp);
            chk($sformatf("vec%0d store", i), 75'(ex_mem_store_data),
                75'((tbl[i].in.valid && !tbl[i].in.flush) ? tbl[i].in.rt : 32'd0));
        end

        // 6*7: nine busy cycles and eight bubbles with the multiplier, one cycle otherwise.
        apply("mul6x7", mul_in);
        chk("mul6x7 alu", 75'(ex_mem_bundle[37:6]), 75'(MULT_EN ? 32'd42 : 32'd0));
        set_inputs(idle_in);
        #1;
        chk("mul6x7 busy after", 75'(ex_busy), '0);
        step();
        chk("mul6x7 one cycle", ex_mem_bundle, '0);

`ifdef EX_MULT_EN
        // Flush in the 4th MULT cycle aborts the multiply.
        set_inputs(mul_in);
        for (int k = 0; k < 4; k++) step();
        flush = 1'b1;
        id_valid = 1'b0;
        step();
        chk("mflush bundle", ex_mem_bundle, '0);
        chk("mflush busy", 75'(ex_busy), '0);
        flush = 1'b0;
        apply("mflush add", add_in);

        // Flush on the completing edge wins over the product.
        set_inputs(mul_in);
        for (int k = 0; k < 8; k++) step();
        flush = 1'b1;
        step();
        chk("cflush bundle", ex_mem_bundle, '0);
        set_inputs(idle_in);
        #1;
        chk("cflush busy", 75'(ex_busy), '0);

        // Reset in the 5th MULT cycle.
        set_inputs(mul_in);
        for (int k = 0; k < 5; k++) step();
        reset = 1'b1;
        id_valid = 1'b0;
        step();
        chk("mreset bundle", ex_mem_bundle, '0);
        chk("mreset store", 75'(ex_mem_store_data), '0);
        chk("mreset busy", 75'(ex_busy), '0);
        reset = 1'b0;
        apply("mreset add", add_in);
`endif

        for (int i = 0; i < 200; i++) begin
            apply($sformatf("rnd%0d", i), rand_in());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 id_valid  in  1  ID/EX carries a real instruction.
REQ-005 id_wb  in  2  {RegWrite, MemtoReg}.
REQ-006 id_m  in  3  {Branch, MemRead, MemWrite}.
REQ-007 id_pc4, id_rs_data, id_rt_data, id_imm  in  32 each  PC+4, operands, sign-extended immediate.
REQ-008 id_rt, id_rd  in  5 each  destination candidates.
REQ-009 id_alu_op  in  2; id_alu_src, id_reg_dst  in  1 each  main-decoder controls.
REQ-010 flush  in  1  the MEM stage's PCSrc; squashes the instruction in EX.
REQ-011 ex_mem_bundle  out  75  registered {WB[1:0], M[2:0], branch_target[31:0], alu_result[31:0], zero, write_reg[4:0]}, MSB first.
REQ-012 ex_mem_store_data  out  32  registered id_rt_data for stores.
REQ-013 ex_busy  out  1  upstream SHALL hold ID/EX inputs stable while high.

Function
REQ-014 SHALL set operand B to id_imm when id_alu_src=1, otherwise to id_rt_data.
REQ-015 ALU control SHALL be: alu_op 00 add; 01 sub; 11 add; 10 decodes funct=id_imm[5:0] as 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt, 0x18 multiply (REQ-027). Any other funct SHALL give result 0.
REQ-016 SHALL wrap all arithmetic modulo 2^32 with no overflow trap.
REQ-017 zero SHALL be 1 iff the 32-bit result equals 0.
REQ-018 branch_target SHALL be id_pc4 + (id_imm << 2), truncated to 32 bits.
REQ-019 write_reg SHALL be id_rd when id_reg_dst=1, otherwise id_rt.
REQ-020 Non-multiply ops: 1-cycle latency; the bundle loads on the edge that ends the presenting cycle.
REQ-021 When id_valid=0, the bundle SHALL load a bubble: WB=0, M=0, all other fields 0.
REQ-022 flush=1 on an edge SHALL load a bubble regardless of other inputs; this overrides REQ-020 and REQ-027.
REQ-023 FSM states SHALL be IDLE and MULT.
REQ-024 IDLE->MULT: id_valid and a multiply op present at an edge without flush; the FSM SHALL latch the operands and clear the 3-bit counter.
REQ-025 In MULT, each cycle SHALL add one 4-bit radix-16 partial product and increment the counter.
REQ-026 MULT->IDLE: on the edge where counter=7, the bundle SHALL load the low 32 product bits with the latched WB, M, write_reg, branch_target and zero.
REQ-027 ex_busy SHALL be high when the state is MULT, or when in IDLE with a valid multiply presented. Busy therefore spans 9 cycles, and the product is in the bundle 9 edges after first presentation.
REQ-028 While in MULT, except on the completing edge, the bundle SHALL load bubbles every edge.
REQ-029 flush while in MULT SHALL abort the multiply: bubble loaded, state IDLE, busy low the next cycle. Flush on the completing edge SHALL win.

Reset
REQ-030 On reset the bundle and ex_mem_store_data SHALL be 0, the state IDLE, the counter 0, and ex_busy 0. This SHALL apply even mid-multiply.
REQ-031 Reset SHALL take priority over flush and id_valid.

Configuration
REQ-032 With macro EX_MULT_EN defined, the multiplier, MULT state and ex_busy logic SHALL be compiled in.
REQ-033 Without EX_MULT_EN, funct 0x18 SHALL produce result 0 with 1-cycle latency, ex_busy SHALL be tied 0, and no FSM SHALL exist.

Verification
REQ-034 Add test: alu_op=10, funct 0x20, rs=5, rt=7, rd=3, reg_dst=1, wb=10 -> next edge: alu_result=12, zero=0, write_reg=3, WB=10.
REQ-035 Branch test: beq, alu_op=01, rs=rt=3, pc4=0x100, imm=4, m=100 -> alu_result=0, zero=1, branch_target=0x110.
REQ-036 Slt test: funct 0x2A, rs=0xFFFFFFFF, rt=1 -> alu_result=1.
REQ-037 Multiply test (EX_MULT_EN): 6*7 -> busy high 9 cycles, 8 bubbles, then alu_result=42 for one cycle, busy 0.
REQ-038 Flush test: flush asserted in the 4th MULT cycle -> bubble, IDLE, busy 0 next cycle. A separate run with flush during an add -> bubble (WB=0, M=0).
REQ-039 Reset test: reset at MULT cycle 5 -> all outputs 0 next edge, and a subsequent add completes normally in 1 cycle.
